// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, the zero-register index
// and the word/register-index types used by every pipeline stage.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write architectural register file.
// Register 0 is hardwired to zero and has no storage. A write presented in
// the same cycle as a read of the same index is bypassed to the read port,
// so the decode stage never sees a stale value.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [1:NREGS-1];
    logic [DATA_W-1:0] regs_d [1:NREGS-1];

    // Zero first, then the write-through value, then stored contents.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
        if (raddr == REG_ZERO) begin
            return '0;
        end else if (we && (raddr == waddr)) begin
            return wdata;
        end else begin
            return regs_q[raddr];
        end
    endfunction

    // Next storage contents: hold everything, overwrite only the targeted entry.
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            for (int i = 1; i < NREGS; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    // Storage update; a reset edge clears every entry and drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = read_port(raddr1);
    assign rdata2 = read_port(raddr2);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus register file for the 5-stage MIPS pipeline.
// Picks ALU result or load data, commits it to the register file, and
// counts committed register writes.
module wb_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Write_address,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [DATA_W-1:0] memdata,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  retire_count
);

    logic [CNT_W-1:0] retire_count_q;
    logic [CNT_W-1:0] retire_count_d;

    // Write-back select, effective write enable, and next retire count.
    always_comb begin
        wb_data        = MemtoReg ? memdata : aluresult;
        wb_we          = RegWrite && (Write_address != REG_ZERO) && rst_n;
        retire_count_d = retire_count_q;
        if (wb_we) begin
            retire_count_d = retire_count_q + CNT_W'(1);
        end
    end

    // Retired-write counter; wraps freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;

    regfile_2r1w #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_we),
        .waddr (Write_address),
        .wdata (wb_data),
        .raddr1(read_addr1),
        .raddr2(read_addr2),
        .rdata1(read_data1),
        .rdata2(read_data2)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile, built with a 4-bit retire counter so
// that counter wrap can be reached quickly.
module tb_wb_regfile;

    import mips_pkg::*;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             MemtoReg;
    logic             RegWrite;
    reg_addr_t        Write_address;
    word_t            aluresult;
    word_t            memdata;
    reg_addr_t        read_addr1;
    reg_addr_t        read_addr2;
    word_t            read_data1;
    word_t            read_data2;
    word_t            wb_data;
    logic             wb_we;
    logic [CNT_W-1:0] retire_count;

    int errors = 0;
    int checks = 0;

    wb_regfile #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .Write_address(Write_address),
        .aluresult    (aluresult),
        .memdata      (memdata),
        .read_addr1   (read_addr1),
        .read_addr2   (read_addr2),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .wb_data      (wb_data),
        .wb_we        (wb_we),
        .retire_count (retire_count)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance past the next rising edge; inputs are changed here, away from edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a write that is not meant to be checked mid-cycle.
    task automatic do_write(input reg_addr_t addr, input word_t value);
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = addr;
        aluresult     = value;
        step();
        RegWrite      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = 5'd5;
        aluresult     = 32'h0000_0077;
        memdata       = 32'h0;
        read_addr1    = 5'd5;
        read_addr2    = 5'd0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (retire_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", retire_count);
        end
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_we: got %b expected 0", wb_we);
        end
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_nobypass: got %h expected 00000000", read_data1);
        end
        checks++;
        if (wb_data !== 32'h0000_0077) begin
            errors++;
            $display("[TB] FAIL reset_wbdata: got %h expected 00000077", wb_data);
        end
    endtask

    task automatic test_write_bypass();
        step();
        rst_n         = 1'b1;
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = 5'd5;
        aluresult     = 32'h0000_00A5;
        read_addr1    = 5'd5;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_00A5) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h expected 000000a5", read_data1);
        end
        checks++;
        if (wb_we !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bypass_we: got %b expected 1", wb_we);
        end
        step();
        RegWrite  = 1'b0;
        aluresult = 32'h0;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_00A5) begin
            errors++;
            $display("[TB] FAIL write_stored: got %h expected 000000a5", read_data1);
        end
        checks++;
        if (retire_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL write_count: got %0d expected 1", retire_count);
        end
    endtask

    task automatic test_memtoreg();
        step();
        RegWrite      = 1'b1;
        MemtoReg      = 1'b1;
        Write_address = 5'd9;
        aluresult     = 32'h1111_1111;
        memdata       = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL memtoreg_wbdata: got %h expected deadbeef", wb_data);
        end
        step();
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        read_addr2 = 5'd9;
        @(negedge clk);
        checks++;
        if (wb_data !== 32'h1111_1111) begin
            errors++;
            $display("[TB] FAIL alu_select_wbdata: got %h expected 11111111", wb_data);
        end
        checks++;
        if (read_data2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL memtoreg_stored: got %h expected deadbeef", read_data2);
        end
        checks++;
        if (retire_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL memtoreg_count: got %0d expected 2", retire_count);
        end
    endtask

    task automatic test_zero_reg();
        step();
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = 5'd0;
        aluresult     = 32'hFFFF_FFFF;
        read_addr1    = 5'd0;
        @(negedge clk);
        checks++;
        if (wb_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_we: got %b expected 0", wb_we);
        end
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zero_read_before: got %h expected 00000000", read_data1);
        end
        step();
        RegWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zero_read_after: got %h expected 00000000", read_data1);
        end
        checks++;
        if (retire_count !== 4'd2) begin
            errors++;
            $display("[TB] FAIL zero_count: got %0d expected 2", retire_count);
        end
    endtask

    task automatic test_regwrite_off();
        step();
        do_write(5'd7, 32'h0000_0055);
        RegWrite      = 1'b0;
        Write_address = 5'd7;
        aluresult     = 32'h0000_1234;
        read_addr1    = 5'd7;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_0055) begin
            errors++;
            $display("[TB] FAIL nowrite_nobypass: got %h expected 00000055", read_data1);
        end
        step();
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_0055) begin
            errors++;
            $display("[TB] FAIL nowrite_held: got %h expected 00000055", read_data1);
        end
        checks++;
        if (retire_count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL nowrite_count: got %0d expected 3", retire_count);
        end
    endtask

    task automatic test_dual_read();
        step();
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = 5'd12;
        aluresult     = 32'h0BAD_F00D;
        read_addr1    = 5'd12;
        read_addr2    = 5'd12;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL dual_bypass_p1: got %h expected 0badf00d", read_data1);
        end
        checks++;
        if (read_data2 !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL dual_bypass_p2: got %h expected 0badf00d", read_data2);
        end
        step();
        RegWrite   = 1'b0;
        read_addr1 = 5'd5;
        read_addr2 = 5'd12;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_00A5) begin
            errors++;
            $display("[TB] FAIL dual_other_reg: got %h expected 000000a5", read_data1);
        end
        checks++;
        if (read_data2 !== 32'h0BAD_F00D) begin
            errors++;
            $display("[TB] FAIL dual_stored: got %h expected 0badf00d", read_data2);
        end
        checks++;
        if (retire_count !== 4'd4) begin
            errors++;
            $display("[TB] FAIL dual_count: got %0d expected 4", retire_count);
        end
    endtask

    task automatic test_reset_mid();
        step();
        do_write(5'd3, 32'h0000_CAFE);
        rst_n         = 1'b0;
        RegWrite      = 1'b1;
        MemtoReg      = 1'b0;
        Write_address = 5'd3;
        aluresult     = 32'h0000_0009;
        read_addr1    = 5'd3;
        read_addr2    = 5'd5;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_CAFE) begin
            errors++;
            $display("[TB] FAIL midreset_nobypass: got %h expected 0000cafe", read_data1);
        end
        checks++;
        if (retire_count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL midreset_count_before: got %0d expected 5", retire_count);
        end
        step();
        rst_n    = 1'b1;
        RegWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_cleared: got %h expected 00000000", read_data1);
        end
        checks++;
        if (read_data2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_other_cleared: got %h expected 00000000", read_data2);
        end
        checks++;
        if (retire_count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d expected 0", retire_count);
        end
        step();
        do_write(5'd3, 32'h0000_0009);
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_0009) begin
            errors++;
            $display("[TB] FAIL postreset_write: got %h expected 00000009", read_data1);
        end
        checks++;
        if (retire_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL postreset_count: got %0d expected 1", retire_count);
        end
    endtask

    task automatic test_counter_wrap();
        logic [CNT_W-1:0] expected;
        step();
        rst_n    = 1'b0;
        RegWrite = 1'b0;
        step();
        rst_n      = 1'b1;
        read_addr1 = 5'd1;
        MemtoReg   = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            RegWrite      = 1'b1;
            Write_address = 5'd1;
            aluresult     = 32'(k) * 32'h0000_0101;
            step();
            expected = CNT_W'(k % 16);
            @(negedge clk);
            checks++;
            if (retire_count !== expected) begin
                errors++;
                $display("[TB] FAIL wrap_count_%0d: got %0d expected %0d", k, retire_count, expected);
            end
        end
        RegWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (read_data1 !== 32'h0000_1111) begin
            errors++;
            $display("[TB] FAIL wrap_last_value: got %h expected 00001111", read_data1);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_write_bypass();
        test_memtoreg();
        test_zero_reg();
        test_regwrite_off();
        test_dual_read();
        test_reset_mid();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
